// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_if
// Purpose  : Bundle of PC-load, instruction-memory, decode and redirect
//            signals around the fetch sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pc_fetch_if;
    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic        pc_write;
    logic [31:0] pc_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        br_take;
    logic [31:0] br_target;
    logic        trap;
    logic        misalign;
    logic [31:0] fetch_cnt;

    modport master (
        input  pc_curr, pc_next, imem_ack, imem_rdata, instr_ready,
               br_take, br_target, trap,
        output pc_write, pc_addr, imem_req, imem_addr, instr_valid,
               instr, instr_pc, misalign, fetch_cnt
    );

    modport slave (
        output pc_curr, pc_next, imem_ack, imem_rdata, instr_ready,
               br_take, br_target, trap,
        input  pc_write, pc_addr, imem_req, imem_addr, instr_valid,
               instr, instr_pc, misalign, fetch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Purpose  : RV32I fetch sequencer: loads the PC, fetches at pc_curr and
//            holds one instruction until decode takes it.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    pc_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] instr_q,     instr_d;
    logic [31:0] instr_pc_q,  instr_pc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        misalign_q,  misalign_d;

    logic        redirect;
    logic        bad_target;
    logic        accept;
    logic        capture;
    logic        pc_write;
    logic [31:0] pc_addr;

    always_comb begin
        // rst_n gating keeps the PC load quiet while reset is held in BOOT
        redirect   = rst_n && (state_q != ST_BOOT) && (bus.trap || bus.br_take);
        bad_target = (bus.br_target[1:0] != 2'b00);
        accept     = (state_q == ST_HOLD)  && bus.instr_ready && !redirect;
        capture    = (state_q == ST_FETCH) && bus.imem_ack    && !redirect;

        pc_write = 1'b0;
        pc_addr  = 32'h0000_0000;
        if (rst_n && (state_q == ST_BOOT)) begin
            pc_write = 1'b1;
            pc_addr  = RESET_VEC;
        end else if (redirect) begin
            pc_write = 1'b1;
            pc_addr  = (bus.trap || bad_target) ? TRAP_VEC : bus.br_target;
        end else if (accept) begin
            pc_write = 1'b1;
            pc_addr  = bus.pc_next;
        end

        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (redirect) state_d = ST_FETCH;
                      else if (capture) state_d = ST_HOLD;
            ST_HOLD:  if (redirect || accept) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase

        instr_d     = capture ? bus.imem_rdata : instr_q;
        instr_pc_d  = capture ? bus.pc_curr    : instr_pc_q;
        fetch_cnt_d = accept  ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        misalign_d  = redirect && bus.br_take && !bus.trap && bad_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            instr_q     <= 32'h0000_0000;
            instr_pc_q  <= 32'h0000_0000;
            fetch_cnt_q <= 32'h0000_0000;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.pc_addr     = pc_addr;
    assign bus.imem_req    = (state_q == ST_FETCH);
    assign bus.imem_addr   = bus.pc_curr;
    assign bus.instr_valid = (state_q == ST_HOLD) && !redirect;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_cnt   = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Purpose  : Directed vector bench for pc_fetch_ctrl with a program-counter
//            model; one vector per clock cycle plus an async-reset sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_q;
    int          checks;
    int          failures;

    pc_fetch_if bus ();

    pc_fetch_ctrl #(
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model; odd reset value makes the BOOT load visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pc_q <= 32'hFFFF_FFF0;
        else if (bus.pc_write) pc_q <= bus.pc_addr;
    end
    assign bus.pc_curr = pc_q;
    assign bus.pc_next = pc_q + 32'd4;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        trp;
        logic        pw;
        logic [31:0] paddr;
        logic        req;
        logic [31:0] iaddr;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        mis;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(
        logic ack, logic [31:0] rdata, logic rdy, logic br, logic [31:0] tgt, logic trp,
        logic pw, logic [31:0] paddr, logic req, logic [31:0] iaddr, logic iv,
        logic [31:0] instr, logic [31:0] ipc, logic mis, logic [31:0] cnt);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.br = br; v.tgt = tgt; v.trp = trp;
        v.pw = pw; v.paddr = paddr; v.req = req; v.iaddr = iaddr; v.iv = iv;
        v.instr = instr; v.ipc = ipc; v.mis = mis; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                         input logic br, input logic [31:0] tgt, input logic trp);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.instr_ready = rdy;
        bus.br_take     = br;
        bus.br_target   = tgt;
        bus.trap        = trp;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " imem_req"},    {31'd0, bus.imem_req},    32'd0);
        chk({tag, " instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        chk({tag, " pc_write"},    {31'd0, bus.pc_write},    32'd0);
        chk({tag, " pc_addr"},     bus.pc_addr,              32'd0);
        chk({tag, " instr"},       bus.instr,                32'd0);
        chk({tag, " instr_pc"},    bus.instr_pc,             32'd0);
        chk({tag, " misalign"},    {31'd0, bus.misalign},    32'd0);
        chk({tag, " fetch_cnt"},   bus.fetch_cnt,            32'd0);
    endtask

    localparam logic [31:0] I0   = 32'h1357_0000;
    localparam logic [31:0] I4   = 32'h1357_0004;
    localparam logic [31:0] I8   = 32'h1357_0008;
    localparam logic [31:0] IC   = 32'h1357_000C;
    localparam logic [31:0] I10  = 32'h1357_0010;
    localparam logic [31:0] I100 = 32'h1357_0100;
    localparam logic [31:0] PRST = 32'hFFFF_FFF0;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        //           ack rdata        rdy br tgt        trp  pw paddr       req iaddr       iv instr ipc         mis cnt
        vecs[0]  = mk(0, 32'd0,        0, 0, 32'd0,     0,   1, 32'h0,      0, PRST,       0, 32'd0, 32'h0,    0, 0);
        vecs[1]  = mk(1, I0,           1, 0, 32'd0,     0,   0, 32'h0,      1, 32'h0,      0, 32'd0, 32'h0,    0, 0);
        vecs[2]  = mk(0, 32'd0,        1, 0, 32'd0,     0,   1, 32'h4,      0, 32'h0,      1, I0,    32'h0,    0, 0);
        vecs[3]  = mk(1, I4,           1, 0, 32'd0,     0,   0, 32'h0,      1, 32'h4,      0, I0,    32'h0,    0, 1);
        vecs[4]  = mk(0, 32'd0,        1, 0, 32'd0,     0,   1, 32'h8,      0, 32'h4,      1, I4,    32'h4,    0, 1);
        vecs[5]  = mk(0, 32'd0,        1, 0, 32'd0,     0,   0, 32'h0,      1, 32'h8,      0, I4,    32'h4,    0, 2);
        vecs[6]  = mk(1, I8,           1, 0, 32'd0,     0,   0, 32'h0,      1, 32'h8,      0, I4,    32'h4,    0, 2);
        vecs[7]  = mk(0, 32'd0,        1, 0, 32'd0,     0,   1, 32'hC,      0, 32'h8,      1, I8,    32'h8,    0, 2);
        vecs[8]  = mk(1, IC,           0, 0, 32'd0,     0,   0, 32'h0,      1, 32'hC,      0, I8,    32'h8,    0, 3);
        for (int i = 9; i <= 13; i++)
            vecs[i] = mk(1, 32'hDEAD_BEEF, 0, 0, 32'd0, 0,   0, 32'h0,      0, 32'hC,      1, IC,    32'hC,    0, 3);
        vecs[14] = mk(0, 32'd0,        1, 0, 32'd0,     0,   1, 32'h10,     0, 32'hC,      1, IC,    32'hC,    0, 3);
        vecs[15] = mk(1, I10,          1, 0, 32'd0,     0,   0, 32'h0,      1, 32'h10,     0, IC,    32'hC,    0, 4);
        vecs[16] = mk(0, 32'd0,        1, 1, 32'hAB4,   0,   1, 32'hAB4,    0, 32'h10,     0, I10,   32'h10,   0, 4);
        vecs[17] = mk(0, 32'd0,        1, 0, 32'd0,     0,   0, 32'h0,      1, 32'hAB4,    0, I10,   32'h10,   0, 4);
        vecs[18] = mk(0, 32'd0,        0, 1, 32'hAB6,   0,   1, 32'h100,    1, 32'hAB4,    0, I10,   32'h10,   0, 4);
        vecs[19] = mk(0, 32'd0,        0, 0, 32'd0,     0,   0, 32'h0,      1, 32'h100,    0, I10,   32'h10,   1, 4);
        vecs[20] = mk(0, 32'd0,        0, 0, 32'd0,     0,   0, 32'h0,      1, 32'h100,    0, I10,   32'h10,   0, 4);
        vecs[21] = mk(1, 32'hCAFE_F00D, 0, 1, 32'hAB4,  1,   1, 32'h100,    1, 32'h100,    0, I10,   32'h10,   0, 4);
        vecs[22] = mk(0, 32'd0,        0, 0, 32'd0,     0,   0, 32'h0,      1, 32'h100,    0, I10,   32'h10,   0, 4);
        vecs[23] = mk(1, I100,         0, 0, 32'd0,     0,   0, 32'h0,      1, 32'h100,    0, I10,   32'h10,   0, 4);
        vecs[24] = mk(0, 32'd0,        0, 0, 32'd0,     0,   0, 32'h0,      0, 32'h100,    1, I100,  32'h100,  0, 4);
        vecs[25] = mk(0, 32'd0,        1, 0, 32'd0,     0,   1, 32'h104,    0, 32'h100,    1, I100,  32'h100,  0, 4);
        // Misaligned redirect from HOLD, then a trap that lands on the pulse cycle
        vecs[26] = mk(1, I100 + 32'h4, 0, 0, 32'd0,     0,   0, 32'h0,      1, 32'h104,    0, I100,  32'h100,  0, 5);
        vecs[27] = mk(0, 32'd0,        1, 1, 32'h201,   0,   1, 32'h100,    0, 32'h104,    0, I100 + 32'h4, 32'h104, 0, 5);
        vecs[28] = mk(0, 32'd0,        0, 0, 32'd0,     1,   1, 32'h100,    1, 32'h100,    0, I100 + 32'h4, 32'h104, 1, 5);
        vecs[29] = mk(0, 32'd0,        0, 0, 32'd0,     0,   0, 32'h0,      1, 32'h100,    0, I100 + 32'h4, 32'h104, 0, 5);

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].br, vecs[i].tgt, vecs[i].trp);
            #3;
            chk($sformatf("v%0d pc_write", i),    {31'd0, bus.pc_write},    {31'd0, vecs[i].pw});
            chk($sformatf("v%0d pc_addr", i),     bus.pc_addr,              vecs[i].paddr);
            chk($sformatf("v%0d imem_req", i),    {31'd0, bus.imem_req},    {31'd0, vecs[i].req});
            chk($sformatf("v%0d imem_addr", i),   bus.imem_addr,            vecs[i].iaddr);
            chk($sformatf("v%0d instr_valid", i), {31'd0, bus.instr_valid}, {31'd0, vecs[i].iv});
            chk($sformatf("v%0d instr", i),       bus.instr,                vecs[i].instr);
            chk($sformatf("v%0d instr_pc", i),    bus.instr_pc,             vecs[i].ipc);
            chk($sformatf("v%0d misalign", i),    {31'd0, bus.misalign},    {31'd0, vecs[i].mis});
            chk($sformatf("v%0d fetch_cnt", i),   bus.fetch_cnt,            vecs[i].cnt);
        end

        // Async reset in the middle of a FETCH wait, away from any clock edge
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("midfetch imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("midfetch imem_addr", bus.imem_addr, 32'h100);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reboot pc_write", {31'd0, bus.pc_write}, 32'd1);
        chk("reboot pc_addr",  bus.pc_addr,           32'h0);
        chk("reboot imem_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("reboot fetch req",  {31'd0, bus.imem_req}, 32'd1);
        chk("reboot fetch addr", bus.imem_addr,         32'h0);
        chk("reboot pc_write off", {31'd0, bus.pc_write}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
